// File: rtl/seven_seg_pkg.sv
// Shared constants and types for the seven-segment scan controller.
package seven_seg_pkg;

    localparam int          BCD_W      = 4;
    localparam logic [3:0]  DIGIT_DASH = 4'hF;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        COMMIT = 2'd2
    } conv_state_e;

    // Double-dabble correction: nibbles of 5 or more must carry after the shift.
    function automatic logic [3:0] dabble_adj(input logic [3:0] nib);
        logic [3:0] res;
        if (nib >= 4'd5) begin
            res = nib + 4'd3;
        end else begin
            res = nib;
        end
        return res;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Serial double-dabble binary-to-BCD converter: one bit per cycle, start/done handshake.
module bin2bcd_seq
    import seven_seg_pkg::*;
#(
    parameter int BIN_W   = 14,
    parameter int NIBBLES = 5
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [BIN_W-1:0]           value,
    output logic                       busy,
    output logic                       done,
    output logic                       bcd_ovf,
    output logic [NIBBLES*BCD_W-1:0]   bcd
);

    localparam int ACC_W = NIBBLES * BCD_W;
    localparam int CNT_W = $clog2(BIN_W + 1);

    conv_state_e        state_r;
    conv_state_e        state_next_s;
    logic [CNT_W-1:0]   cnt_r;
    logic [BIN_W-1:0]   sh_r;
    logic [ACC_W-1:0]   acc_r;
    logic [ACC_W-1:0]   adj_s;
    logic               acc_ovf_r;
    logic               busy_r;
    logic               done_r;
    logic               busy_next_s;
    logic               done_next_s;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_next_s = SHIFT;
                end else begin
                    state_next_s = IDLE;
                end
            end
            SHIFT: begin
                if (cnt_r == CNT_W'(BIN_W - 1)) begin
                    state_next_s = COMMIT;
                end else begin
                    state_next_s = SHIFT;
                end
            end
            COMMIT:  state_next_s = IDLE;
            default: state_next_s = IDLE;
        endcase
    end

    // Output decode, taken from the next state so busy/done can be registered without lag
    always_comb begin
        busy_next_s = 1'b0;
        done_next_s = 1'b0;
        case (state_next_s)
            IDLE:    begin busy_next_s = 1'b0; done_next_s = 1'b0; end
            SHIFT:   begin busy_next_s = 1'b1; done_next_s = 1'b0; end
            COMMIT:  begin busy_next_s = 1'b1; done_next_s = 1'b1; end
            default: begin busy_next_s = 1'b0; done_next_s = 1'b0; end
        endcase
    end

    // Per-nibble add-3 correction ahead of each shift
    always_comb begin
        adj_s = '0;
        for (int n = 0; n < NIBBLES; n++) begin
            adj_s[n*BCD_W +: BCD_W] = dabble_adj(acc_r[n*BCD_W +: BCD_W]);
        end
    end

    // Datapath: capture on start, shift one bit per SHIFT cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r     <= '0;
            sh_r      <= '0;
            acc_r     <= '0;
            acc_ovf_r <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            busy_r <= busy_next_s;
            done_r <= done_next_s;
            case (state_r)
                IDLE: begin
                    if (start) begin
                        cnt_r     <= '0;
                        sh_r      <= value;
                        acc_r     <= '0;
                        acc_ovf_r <= 1'b0;
                    end
                end
                SHIFT: begin
                    // A set MSB about to leave the top nibble means the value did not fit.
                    acc_ovf_r <= acc_ovf_r | adj_s[ACC_W-1];
                    acc_r     <= {adj_s[ACC_W-2:0], sh_r[BIN_W-1]};
                    sh_r      <= {sh_r[BIN_W-2:0], 1'b0};
                    cnt_r     <= cnt_r + CNT_W'(1);
                end
                default: begin
                    cnt_r <= cnt_r;
                end
            endcase
        end
    end

    assign busy    = busy_r;
    assign done    = done_r;
    assign bcd_ovf = acc_ovf_r;
    assign bcd     = acc_r;

endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// Seven-segment sequencer: serial BCD conversion, leading-zero blanking and digit multiplexing
// onto a single external decoder.
module seven_seg_scan_ctrl
    import seven_seg_pkg::*;
#(
    parameter int DIGITS   = 4,
    parameter int BIN_W    = 14,
    parameter int SCAN_DIV = 50000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic [BIN_W-1:0]   value,
    input  logic               lz_blank,
    output logic               busy,
    output logic               overflow,
    output logic [3:0]         digit_code,
    output logic               digit_blank,
    output logic [DIGITS-1:0]  digit_sel
);

    localparam int ACC_N = DIGITS + 1;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int TMR_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DIGITS-1:0] SEL_ONE = {{(DIGITS-1){1'b0}}, 1'b1};

    logic                         conv_busy_s;
    logic                         conv_done_s;
    logic                         bcd_ovf_s;
    logic [ACC_N*BCD_W-1:0]       bcd_s;
    logic                         accept_s;
    logic                         lz_shadow_r;

    logic [DIGITS-1:0][3:0]       disp_code_r;
    logic [DIGITS-1:0]            disp_blank_r;
    logic                         overflow_r;
    logic [DIGITS-1:0][3:0]       commit_code_s;
    logic [DIGITS-1:0]            commit_blank_s;
    logic                         commit_ovf_s;
    logic                         zero_run_s;

    logic [TMR_W-1:0]             timer_r;
    logic [IDX_W-1:0]             idx_r;
    logic [IDX_W-1:0]             idx_inc_s;
    logic [IDX_W-1:0]             show_idx_s;
    logic                         wrap_s;

    logic [DIGITS-1:0]            digit_sel_r;
    logic [3:0]                   digit_code_r;
    logic                         digit_blank_r;

    assign accept_s = load && !conv_busy_s;

    bin2bcd_seq #(
        .BIN_W   (BIN_W),
        .NIBBLES (ACC_N)
    ) u_bin2bcd (
        .clk     (clk),
        .rst     (rst),
        .start   (accept_s),
        .value   (value),
        .busy    (conv_busy_s),
        .done    (conv_done_s),
        .bcd_ovf (bcd_ovf_s),
        .bcd     (bcd_s)
    );

    // Capture the blanking mode alongside the accepted value
    always_ff @(posedge clk) begin
        if (rst) begin
            lz_shadow_r <= 1'b0;
        end else if (accept_s) begin
            lz_shadow_r <= lz_blank;
        end
    end

    // Display image to commit: dashes on overflow, else digits with leading-zero flags
    always_comb begin
        commit_code_s  = '0;
        commit_blank_s = '0;
        zero_run_s     = 1'b1;
        commit_ovf_s   = bcd_ovf_s || (bcd_s[ACC_N*BCD_W-1 -: BCD_W] != 4'h0);
        for (int i = DIGITS - 1; i >= 0; i--) begin
            zero_run_s = zero_run_s && (bcd_s[i*BCD_W +: BCD_W] == 4'h0);
            if (commit_ovf_s) begin
                commit_code_s[i]  = DIGIT_DASH;
                commit_blank_s[i] = 1'b0;
            end else begin
                commit_code_s[i]  = bcd_s[i*BCD_W +: BCD_W];
                commit_blank_s[i] = lz_shadow_r && zero_run_s && (i != 0);
            end
        end
    end

    // Display registers change only when a conversion completes
    always_ff @(posedge clk) begin
        if (rst) begin
            disp_code_r  <= '0;
            disp_blank_r <= '0;
            overflow_r   <= 1'b0;
        end else if (conv_done_s) begin
            disp_code_r  <= commit_code_s;
            disp_blank_r <= commit_blank_s;
            overflow_r   <= commit_ovf_s;
        end
    end

    // Scan sequencing: index of the digit to present after this edge
    always_comb begin
        wrap_s = (timer_r == TMR_W'(SCAN_DIV - 1));
        if (idx_r == IDX_W'(DIGITS - 1)) begin
            idx_inc_s = IDX_W'(0);
        end else begin
            idx_inc_s = idx_r + IDX_W'(1);
        end
        if (wrap_s) begin
            show_idx_s = idx_inc_s;
        end else begin
            show_idx_s = idx_r;
        end
    end

    // Free-running scan timer and index
    always_ff @(posedge clk) begin
        if (rst) begin
            timer_r <= '0;
            idx_r   <= '0;
        end else if (wrap_s) begin
            timer_r <= '0;
            idx_r   <= idx_inc_s;
        end else begin
            timer_r <= timer_r + TMR_W'(1);
        end
    end

    // Registered decoder drive; refreshed every edge so a commit shows up mid-slot
    always_ff @(posedge clk) begin
        if (rst) begin
            digit_sel_r   <= ~SEL_ONE;
            digit_code_r  <= 4'h0;
            digit_blank_r <= 1'b0;
        end else begin
            digit_sel_r   <= ~(SEL_ONE << show_idx_s);
            digit_code_r  <= disp_code_r[show_idx_s];
            digit_blank_r <= disp_blank_r[show_idx_s];
        end
    end

    assign busy        = conv_busy_s;
    assign overflow    = overflow_r;
    assign digit_code  = digit_code_r;
    assign digit_blank = digit_blank_r;
    assign digit_sel   = digit_sel_r;

endmodule
